frame_strobe_sequencer: RTL and testbench
=========================================

# frame_strobe_sequencer

Sequences configuration frames into one fabric column: accepts frame writes over a valid/ready handshake, drives `FrameData` and a one-hot `FrameStrobe` pulse into the column's tile chain (e.g. N_term_s1 at the column top), and tracks progress and errors. It sits between the configuration front end (bitstream parser) and the per-column `FrameStrobe`/`FrameData` buses, one instance per column.

## Interface
- `MaxFramesPerCol`, 20: frames per column; width of `FrameStrobe`.
- `FrameBitsPerRow`, 32: width of `FrameData` and `cfg_data`.
- `StrobeWidth`, 1: cycles the strobe bit stays high (≥1).
- `HoldCycles`, 1: cycles `FrameData` is held after the strobe falls (≥1).
- `IdxW`, `$clog2(MaxFramesPerCol)` (5): frame index width.

Ports:
- `UserCLK`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_valid`  in  1  frame write request.
- `cfg_ready`  out  1  block can accept a frame.
- `cfg_frame_idx`  in  IdxW  target frame index.
- `cfg_data`  in  FrameBitsPerRow  frame payload.
- `cfg_last`  in  1  marks final frame of a column load.
- `cfg_clear`  in  1  single-cycle pulse; clears status.
- `FrameData`  out  FrameBitsPerRow  registered column data.
- `FrameStrobe`  out  MaxFramesPerCol  registered one-hot strobe.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  sticky; last frame completed.
- `err_idx`  out  1  sticky; out-of-range index received.
- `frame_count`  out  16  frames strobed since reset/clear.

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: `cfg_ready`=1 (0 while `rst` is high). Handshake = `cfg_valid && cfg_ready`. On handshake, latch idx, data and last.
  - Idx < MaxFramesPerCol: go to SETUP.
  - Idx ≥ MaxFramesPerCol: stay in IDLE, set `err_idx`, no strobe, count unchanged. If last, set `done`.
- SETUP (1 cycle): `FrameData`=latched data, `FrameStrobe`=0.
- STROBE (StrobeWidth cycles, down-counter): `FrameStrobe[idx]`=1, all other bits 0, `FrameData` held.
- HOLD (HoldCycles cycles): `FrameStrobe`=0, `FrameData` held. On exit to IDLE:
  - `frame_count` += 1, saturating at 0xFFFF.
  - If latched last, set `done`.
  - `FrameData` returns to 0 in IDLE.
- `cfg_clear` clears `done`, `err_idx` and `frame_count` in any state without aborting a frame in flight.
  - Clear and a count/flag update in the same cycle: the clear applies first, then the update. Result is count=1, or the flag set.
- `cfg_valid` outside IDLE is ignored. The requester must hold `cfg_valid` and its inputs until the handshake.
- At most one `FrameStrobe` bit is ever high. It is never high during SETUP, HOLD or IDLE.

## Timing
- Reset values: `FrameData`=0, `FrameStrobe`=0, `busy`=0, `done`=0, `err_idx`=0, `frame_count`=0, state=IDLE. `cfg_ready`=1 on the first cycle after `rst` falls.
- Handshake at edge N → SETUP in cycle N+1 → strobe high in cycles N+2 … N+1+StrobeWidth → HOLD → IDLE with `cfg_ready`=1 at cycle N+2+StrobeWidth+HoldCycles.
- With defaults: 4-cycle frame period, strobe high exactly 1 cycle. `FrameData` is stable 1 cycle before, during, and HoldCycles after the strobe.
- `frame_count` and `done` update at the HOLD→IDLE edge and are visible in the first IDLE cycle.
- Out-of-range `err_idx`/`done` are visible the cycle after the handshake.
- `rst` mid-frame: at the next edge all outputs return to reset values. The frame is lost and not counted.

## Structure
- Shared package `frame_seq_pkg` holds:
  - state encoding (IDLE=0, SETUP=1, STROBE=2, HOLD=3);
  - `frame_count` width (16);
  - a helper function for index width.
- Sub-module `frame_strobe_decode`: registered IdxW→MaxFramesPerCol one-hot decoder with enable. It outputs 0 when disabled or when the index is out of range.
- The remaining logic (FSM, strobe/hold counters, status) lives in the top module.

## Test plan
- Reset, then idx=3, data=0xA5A5_5A5A, last=1 → `FrameStrobe`=1<<3 for exactly 1 cycle at N+2; `FrameData`=0xA5A5_5A5A over N+1..N+3; `frame_count`=1; `done`=1; `cfg_ready` back at N+4.
- Back-to-back idx 0..19 with `cfg_valid` held high → 20 strobes, each one-hot and in order, 4-cycle period; `frame_count`=20; no overlapping strobes.
- idx=20 and idx=31 with last=1 → no strobe; `err_idx`=1 and `done`=1 next cycle; `frame_count` unchanged; `cfg_ready` stays 1.
- StrobeWidth=3, HoldCycles=2 → strobe high 3 cycles; data held 2 cycles after; period 7 cycles.
- `rst` asserted during STROBE → next cycle strobe=0, `FrameData`=0, `frame_count`=0; a subsequent frame completes normally.
- `cfg_clear` on the HOLD→IDLE edge with `frame_count`=5 → `frame_count`=1; preload 0xFFFF and strobe again → stays 0xFFFF.

Source files
------------

// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the per-column frame strobe sequencer.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } seq_state_t;

    localparam int CountW = 16;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_strobe_sequencer_if.sv
// Frame-write handshake between the bitstream front end and one column sequencer.
interface frame_strobe_sequencer_if #(
    parameter int IdxW            = 5,
    parameter int FrameBitsPerRow = 32
);
    logic                       cfg_valid;
    logic                       cfg_ready;
    logic [IdxW-1:0]            cfg_frame_idx;
    logic [FrameBitsPerRow-1:0] cfg_data;
    logic                       cfg_last;
    logic                       cfg_clear;

    modport master (
        output cfg_valid, cfg_frame_idx, cfg_data, cfg_last, cfg_clear,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_frame_idx, cfg_data, cfg_last, cfg_clear,
        output cfg_ready
    );
endinterface

// File: rtl/frame_strobe_decode.sv
// Registered index-to-one-hot decoder driving the column FrameStrobe bus.
module frame_strobe_decode #(
    parameter int MaxFramesPerCol = 20,
    parameter int IdxW            = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [IdxW-1:0]            idx,
    output logic [MaxFramesPerCol-1:0] strobe
);
    localparam logic [IdxW:0]            MaxIdx = (IdxW+1)'(MaxFramesPerCol);
    localparam logic [MaxFramesPerCol-1:0] OneBit = MaxFramesPerCol'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe <= '0;
        end else if (en && ({1'b0, idx} < MaxIdx)) begin
            strobe <= OneBit << idx;
        end else begin
            strobe <= '0;
        end
    end
endmodule

// File: rtl/frame_strobe_sequencer.sv
// Sequences configuration frames into one fabric column: SETUP, one-hot strobe, hold,
// with sticky done/error status and a saturating frame counter.
module frame_strobe_sequencer
    import frame_seq_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int StrobeWidth     = 1,
    parameter int HoldCycles      = 1,
    parameter int IdxW            = idx_width(MaxFramesPerCol)
) (
    input  logic                       UserCLK,
    input  logic                       rst,
    frame_strobe_sequencer_if.slave    cfg,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       done,
    output logic                       err_idx,
    output logic [CountW-1:0]          frame_count
);
    localparam int              MaxCnt     = (StrobeWidth > HoldCycles) ? StrobeWidth : HoldCycles;
    localparam int              CntW       = idx_width(MaxCnt);
    localparam logic [IdxW:0]   MaxIdx     = (IdxW+1)'(MaxFramesPerCol);
    localparam logic [CntW-1:0] StrobeLoad = CntW'(StrobeWidth - 1);
    localparam logic [CntW-1:0] HoldLoad   = CntW'(HoldCycles - 1);

    seq_state_t        state, state_next;
    logic [CntW-1:0]   cnt, cnt_next;
    logic [IdxW-1:0]   idx_q;
    logic              last_q;
    logic              handshake, idx_ok, frame_done, strobe_en;
    logic [CountW-1:0] count_base, count_next;
    logic              done_next, err_next;

    assign cfg.cfg_ready = (state == IDLE) && !rst;
    assign handshake     = cfg.cfg_valid && cfg.cfg_ready;
    assign idx_ok        = {1'b0, cfg.cfg_frame_idx} < MaxIdx;
    assign busy          = (state != IDLE);
    assign strobe_en     = (state_next == STROBE);

    always_ff @(posedge UserCLK) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // STROBE and HOLD share one down-counter, reloaded on entry to each phase.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (handshake && idx_ok) state_next = SETUP;
            end
            SETUP: begin
                state_next = STROBE;
                cnt_next   = StrobeLoad;
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_next = HOLD;
                    cnt_next   = HoldLoad;
                end else begin
                    cnt_next = cnt - CntW'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end else begin
                    cnt_next = cnt - CntW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A clear in the same cycle as an update wipes the old value first, then the update lands.
    always_comb begin
        count_base = cfg.cfg_clear ? '0 : frame_count;
        count_next = count_base;
        if (frame_done && (count_base != '1)) count_next = count_base + CountW'(1);
        done_next = (done && !cfg.cfg_clear) || (frame_done && last_q)
                  || (handshake && !idx_ok && cfg.cfg_last);
        err_next  = (err_idx && !cfg.cfg_clear) || (handshake && !idx_ok);
    end

    always_ff @(posedge UserCLK) begin
        if (rst) begin
            idx_q       <= '0;
            last_q      <= 1'b0;
            FrameData   <= '0;
            done        <= 1'b0;
            err_idx     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (handshake) begin
                idx_q  <= cfg.cfg_frame_idx;
                last_q <= cfg.cfg_last;
            end
            if (state_next == IDLE) FrameData <= '0;
            else if (handshake)     FrameData <= cfg.cfg_data;
            done        <= done_next;
            err_idx     <= err_next;
            frame_count <= count_next;
        end
    end

    frame_strobe_decode #(
        .MaxFramesPerCol(MaxFramesPerCol),
        .IdxW           (IdxW)
    ) u_decode (
        .clk   (UserCLK),
        .rst   (rst),
        .en    (strobe_en),
        .idx   (idx_q),
        .strobe(FrameStrobe)
    );
endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Directed bench for frame_strobe_sequencer: default instance plus a StrobeWidth=3/HoldCycles=2 instance.
module tb_frame_strobe_sequencer;
    import frame_seq_pkg::*;

    localparam int NFrames = 20;
    localparam int Bits    = 32;
    localparam int IdxW    = 5;

    logic UserCLK = 1'b0;
    logic rst;
    always #5 UserCLK = ~UserCLK;

    frame_strobe_sequencer_if #(.IdxW(IdxW), .FrameBitsPerRow(Bits)) cfg_a ();
    frame_strobe_sequencer_if #(.IdxW(IdxW), .FrameBitsPerRow(Bits)) cfg_b ();

    logic [Bits-1:0]    data_a, data_b;
    logic [NFrames-1:0] strobe_a, strobe_b;
    logic               busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [CountW-1:0]  count_a, count_b;

    frame_strobe_sequencer #(
        .MaxFramesPerCol(NFrames), .FrameBitsPerRow(Bits), .StrobeWidth(1), .HoldCycles(1)
    ) dut_a (
        .UserCLK(UserCLK), .rst(rst), .cfg(cfg_a),
        .FrameData(data_a), .FrameStrobe(strobe_a), .busy(busy_a),
        .done(done_a), .err_idx(err_a), .frame_count(count_a)
    );

    frame_strobe_sequencer #(
        .MaxFramesPerCol(NFrames), .FrameBitsPerRow(Bits), .StrobeWidth(3), .HoldCycles(2)
    ) dut_b (
        .UserCLK(UserCLK), .rst(rst), .cfg(cfg_b),
        .FrameData(data_b), .FrameStrobe(strobe_b), .busy(busy_b),
        .done(done_b), .err_idx(err_b), .frame_count(count_b)
    );

    typedef struct packed {
        logic [IdxW-1:0]    idx;
        logic [Bits-1:0]    data;
        logic               last;
        logic [NFrames-1:0] exp_strobe;
        logic               exp_err;
        logic               exp_done;
        logic [CountW-1:0]  exp_count;
    } vec_t;

    vec_t vecs[6];
    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge with DUT A idle; returns at a negedge with DUT A idle again.
    task automatic applyStimulus(input vec_t v);
        logic in_range;
        in_range = (v.idx < 5'd20);
        checkOutput("ready_before", 64'(cfg_a.cfg_ready), 64'(1));
        cfg_a.cfg_valid     = 1'b1;
        cfg_a.cfg_frame_idx = v.idx;
        cfg_a.cfg_data      = v.data;
        cfg_a.cfg_last      = v.last;
        @(posedge UserCLK);
        @(negedge UserCLK);
        cfg_a.cfg_valid = 1'b0;
        if (!in_range) begin
            checkOutput("oor_strobe", 64'(strobe_a), 64'(0));
            checkOutput("oor_err", 64'(err_a), 64'(v.exp_err));
            checkOutput("oor_done", 64'(done_a), 64'(v.exp_done));
            checkOutput("oor_count", 64'(count_a), 64'(v.exp_count));
            checkOutput("oor_ready", 64'(cfg_a.cfg_ready), 64'(1));
            checkOutput("oor_busy", 64'(busy_a), 64'(0));
        end else begin
            checkOutput("setup_strobe", 64'(strobe_a), 64'(0));
            checkOutput("setup_data", 64'(data_a), 64'(v.data));
            checkOutput("setup_ready", 64'(cfg_a.cfg_ready), 64'(0));
            checkOutput("setup_busy", 64'(busy_a), 64'(1));
            @(negedge UserCLK);
            checkOutput("strobe_bits", 64'(strobe_a), 64'(v.exp_strobe));
            checkOutput("strobe_data", 64'(data_a), 64'(v.data));
            @(negedge UserCLK);
            checkOutput("hold_strobe", 64'(strobe_a), 64'(0));
            checkOutput("hold_data", 64'(data_a), 64'(v.data));
            @(negedge UserCLK);
            checkOutput("idle_ready", 64'(cfg_a.cfg_ready), 64'(1));
            checkOutput("idle_data", 64'(data_a), 64'(0));
            checkOutput("idle_count", 64'(count_a), 64'(v.exp_count));
            checkOutput("idle_done", 64'(done_a), 64'(v.exp_done));
            checkOutput("idle_err", 64'(err_a), 64'(v.exp_err));
        end
    endtask

    task automatic pulseClear();
        cfg_a.cfg_clear = 1'b1;
        @(negedge UserCLK);
        cfg_a.cfg_clear = 1'b0;
        checkOutput("clear_count", 64'(count_a), 64'(0));
        checkOutput("clear_done", 64'(done_a), 64'(0));
        checkOutput("clear_err", 64'(err_a), 64'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NFrames-1:0] one;
        logic [NFrames-1:0] exp_s;
        logic [Bits-1:0]    b_data;
        vec_t v;
        one = NFrames'(1);

        vecs[0] = '{idx: 5'd3,  data: 32'hA5A5_5A5A, last: 1'b1, exp_strobe: 20'h00008, exp_err: 1'b0, exp_done: 1'b1, exp_count: 16'd1};
        vecs[1] = '{idx: 5'd0,  data: 32'h0000_0001, last: 1'b0, exp_strobe: 20'h00001, exp_err: 1'b0, exp_done: 1'b0, exp_count: 16'd1};
        vecs[2] = '{idx: 5'd19, data: 32'hFFFF_FFFF, last: 1'b0, exp_strobe: 20'h80000, exp_err: 1'b0, exp_done: 1'b0, exp_count: 16'd2};
        vecs[3] = '{idx: 5'd20, data: 32'hDEAD_BEEF, last: 1'b1, exp_strobe: 20'h00000, exp_err: 1'b1, exp_done: 1'b1, exp_count: 16'd2};
        vecs[4] = '{idx: 5'd31, data: 32'h0000_0000, last: 1'b1, exp_strobe: 20'h00000, exp_err: 1'b1, exp_done: 1'b1, exp_count: 16'd2};
        vecs[5] = '{idx: 5'd7,  data: 32'h1234_5678, last: 1'b0, exp_strobe: 20'h00080, exp_err: 1'b1, exp_done: 1'b1, exp_count: 16'd3};

        rst = 1'b1;
        cfg_a.cfg_valid = 1'b0; cfg_a.cfg_frame_idx = '0; cfg_a.cfg_data = '0;
        cfg_a.cfg_last  = 1'b0; cfg_a.cfg_clear     = 1'b0;
        cfg_b.cfg_valid = 1'b0; cfg_b.cfg_frame_idx = '0; cfg_b.cfg_data = '0;
        cfg_b.cfg_last  = 1'b0; cfg_b.cfg_clear     = 1'b0;

        repeat (3) @(negedge UserCLK);
        checkOutput("rst_ready", 64'(cfg_a.cfg_ready), 64'(0));
        checkOutput("rst_strobe", 64'(strobe_a), 64'(0));
        checkOutput("rst_data", 64'(data_a), 64'(0));
        checkOutput("rst_count", 64'(count_a), 64'(0));
        rst = 1'b0;
        @(negedge UserCLK);
        checkOutput("post_rst_ready", 64'(cfg_a.cfg_ready), 64'(1));
        checkOutput("post_rst_busy", 64'(busy_a), 64'(0));
        checkOutput("post_rst_done", 64'(done_a), 64'(0));
        checkOutput("post_rst_err", 64'(err_a), 64'(0));

        applyStimulus(vecs[0]);
        pulseClear();
        for (int i = 1; i < 6; i++) applyStimulus(vecs[i]);

        // Back-to-back frames 0..19 with cfg_valid held: frame k strobes at cycle 4k+1 after the first handshake edge.
        pulseClear();
        cfg_a.cfg_valid = 1'b1; cfg_a.cfg_frame_idx = 5'd0; cfg_a.cfg_data = 32'h100; cfg_a.cfg_last = 1'b0;
        @(posedge UserCLK);
        for (int c = 0; c < 4 * NFrames; c++) begin
            int k, p;
            @(negedge UserCLK);
            k = c / 4;
            p = c % 4;
            exp_s = (p == 1) ? (one << k) : '0;
            checkOutput("b2b_strobe", 64'(strobe_a), 64'(exp_s));
            if (p == 0) begin
                checkOutput("b2b_data", 64'(data_a), 64'(32'h100 + k));
                if (k < NFrames - 1) begin
                    cfg_a.cfg_frame_idx = IdxW'(k + 1);
                    cfg_a.cfg_data      = 32'(32'h100 + k + 1);
                    cfg_a.cfg_last      = (k + 1 == NFrames - 1);
                end else begin
                    cfg_a.cfg_valid = 1'b0;
                end
            end
            if (p == 3) checkOutput("b2b_ready", 64'(cfg_a.cfg_ready), 64'(1));
            if (c != 4 * NFrames - 1) @(posedge UserCLK);
        end
        checkOutput("b2b_count", 64'(count_a), 64'(20));
        checkOutput("b2b_done", 64'(done_a), 64'(1));
        checkOutput("b2b_err", 64'(err_a), 64'(0));
        cfg_a.cfg_last = 1'b0;

        // Reset while the strobe is high drops the frame without counting it.
        cfg_a.cfg_valid = 1'b1; cfg_a.cfg_frame_idx = 5'd5; cfg_a.cfg_data = 32'h5555_AAAA;
        @(posedge UserCLK);
        @(negedge UserCLK);
        cfg_a.cfg_valid = 1'b0;
        @(negedge UserCLK);
        checkOutput("pre_rst_strobe", 64'(strobe_a), 64'(one << 5));
        rst = 1'b1;
        @(negedge UserCLK);
        checkOutput("midrst_strobe", 64'(strobe_a), 64'(0));
        checkOutput("midrst_data", 64'(data_a), 64'(0));
        checkOutput("midrst_count", 64'(count_a), 64'(0));
        checkOutput("midrst_busy", 64'(busy_a), 64'(0));
        checkOutput("midrst_done", 64'(done_a), 64'(0));
        rst = 1'b0;
        @(negedge UserCLK);
        v = '{idx: 5'd9, data: 32'h0F0F_0F0F, last: 1'b0, exp_strobe: 20'h00200, exp_err: 1'b0, exp_done: 1'b0, exp_count: 16'd1};
        applyStimulus(v);

        for (int i = 0; i < 4; i++) begin
            v = '{idx: IdxW'(10 + i), data: 32'(32'hC000 + i), last: 1'b0, exp_strobe: one << (10 + i),
                  exp_err: 1'b0, exp_done: 1'b0, exp_count: CountW'(2 + i)};
            applyStimulus(v);
        end

        // Clear landing on the HOLD->IDLE edge with count at 5.
        cfg_a.cfg_valid = 1'b1; cfg_a.cfg_frame_idx = 5'd14; cfg_a.cfg_data = 32'h0000_00EE;
        @(posedge UserCLK);
        @(negedge UserCLK);
        cfg_a.cfg_valid = 1'b0;
        @(negedge UserCLK);
        @(negedge UserCLK);
        checkOutput("preclear_count", 64'(count_a), 64'(5));
        cfg_a.cfg_clear = 1'b1;
        @(negedge UserCLK);
        cfg_a.cfg_clear = 1'b0;
        checkOutput("clear_hold_count", 64'(count_a), 64'(1));
        checkOutput("clear_hold_ready", 64'(cfg_a.cfg_ready), 64'(1));

        force dut_a.frame_count = 16'hFFFF;
        @(negedge UserCLK);
        release dut_a.frame_count;
        @(negedge UserCLK);
        checkOutput("preload_count", 64'(count_a), 64'(16'hFFFF));
        v = '{idx: 5'd15, data: 32'h7777_1111, last: 1'b1, exp_strobe: 20'h08000, exp_err: 1'b0, exp_done: 1'b1, exp_count: 16'hFFFF};
        applyStimulus(v);

        // Wide strobe instance: 3 strobe cycles, 2 hold cycles, 7-cycle period.
        b_data = 32'hC3C3_3C3C;
        cfg_b.cfg_valid = 1'b1; cfg_b.cfg_frame_idx = 5'd2; cfg_b.cfg_data = b_data; cfg_b.cfg_last = 1'b1;
        @(posedge UserCLK);
        for (int c = 1; c <= 7; c++) begin
            @(negedge UserCLK);
            if (c == 1) cfg_b.cfg_valid = 1'b0;
            exp_s = (c >= 2 && c <= 4) ? (one << 2) : '0;
            checkOutput("wide_strobe", 64'(strobe_b), 64'(exp_s));
            checkOutput("wide_data", 64'(data_b), 64'((c <= 6) ? b_data : 32'h0));
            checkOutput("wide_ready", 64'(cfg_b.cfg_ready), 64'(c == 7));
            checkOutput("wide_busy", 64'(busy_b), 64'(c != 7));
        end
        checkOutput("wide_count", 64'(count_b), 64'(1));
        checkOutput("wide_done", 64'(done_b), 64'(1));
        checkOutput("wide_err", 64'(err_b), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
